motor_sequencer: RTL and testbench

- Parametrised successor to the two-motor / LED controller.
- Drives N_MOTORS bidirectional motors, one at a time, using a Moore FSM.
- Replaces delay-based timers with synthesizable cycle counters for run time and dead time.
- Supports single-motor and sequence-all modes, a global stop, and per-phase status LEDs; sits between the operator input decode and the motor H-bridge drivers.

---
 rtl/motor_sequencer.sv | 161 ++++++++++++++++
 tb/tb_motor_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : motor_sequencer
// Purpose  : Drives N bidirectional motors one at a time with timed run/dead-time phases.
// Revision : 1.0
// ============================================================================
module motor_sequencer #(
    parameter int N_MOTORS     = 2,
    parameter int SEL_W        = 1,
    parameter int RUN_CYCLES   = 10,
    parameter int PAUSE_CYCLES = 5,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stop,
    input  logic                  cmd_valid,
    input  logic [SEL_W-1:0]      cmd_motor,
    input  logic                  cmd_dir,
    input  logic                  cmd_seq,
    output logic                  cmd_ready,
    output logic [2*N_MOTORS-1:0] motor_dir,
    output logic [N_MOTORS-1:0]   motor_en,
    output logic                  led_idle,
    output logic                  led_run,
    output logic                  led_pause,
    output logic                  led_stop,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [SEL_W-1:0] c_IDX_LAST   = SEL_W'(N_MOTORS - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_idx, w_idx_nxt;
    logic [SEL_W-1:0]   r_steps, w_steps_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_seq, w_seq_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               w_cmd_ok;

    assign w_cmd_ok = ({{(32-SEL_W){1'b0}}, cmd_motor} < 32'(N_MOTORS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_steps <= '0;
            r_dir   <= 1'b0;
            r_seq   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_steps <= w_steps_nxt;
            r_dir   <= w_dir_nxt;
            r_seq   <= w_seq_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_steps_nxt = r_steps;
        w_dir_nxt   = r_dir;
        w_seq_nxt   = r_seq;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        // Stop outranks timer expiry and command acceptance in every state.
        if (stop) begin
            w_state_nxt = S_STOP;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_steps_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && w_cmd_ok) begin
                        w_state_nxt = S_RUN;
                        w_idx_nxt   = cmd_motor;
                        w_dir_nxt   = cmd_dir;
                        w_seq_nxt   = cmd_seq;
                        w_steps_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else if (cmd_valid) begin
                        w_err_nxt = 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_RUN_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (r_cnt == c_PAUSE_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_seq && (r_steps != c_IDX_LAST)) begin
                            w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + SEL_W'(1);
                            w_steps_nxt = r_steps + SEL_W'(1);
                            w_state_nxt = S_RUN;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        motor_en  = '0;
        motor_dir = '0;
        for (int i = 0; i < N_MOTORS; i++) begin
            motor_en[i]      = (r_state == S_RUN) && (r_idx == SEL_W'(i));
            motor_dir[2*i]   = (r_state == S_RUN) && (r_idx == SEL_W'(i)) && !r_dir;
            motor_dir[2*i+1] = (r_state == S_RUN) && (r_idx == SEL_W'(i)) && r_dir;
        end
    end

    assign led_idle  = (r_state == S_IDLE);
    assign led_run   = (r_state == S_RUN);
    assign led_pause = (r_state == S_PAUSE);
    assign led_stop  = (r_state == S_STOP);
    assign busy      = led_run || led_pause;
    assign done      = r_done;
    assign cmd_err   = r_err;
    assign cmd_ready = led_idle && !stop && reset;

endmodule
`default_nettype wire

// File: tb/tb_motor_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_motor_sequencer
// Purpose  : Randomized scoreboard bench for motor_sequencer (3 motors, 6/3 cycles).
// Revision : 1.0
// ============================================================================
module tb_motor_sequencer;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int RC = 6;
    localparam int PC = 3;
    localparam int CW = 4;
    localparam int W  = 8 + 3*N;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_STOP  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            stop = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [SW-1:0]   cmd_motor = '0;
    logic            cmd_dir = 1'b0;
    logic            cmd_seq = 1'b0;
    logic            cmd_ready;
    logic [2*N-1:0]  motor_dir;
    logic [N-1:0]    motor_en;
    logic            led_idle, led_run, led_pause, led_stop;
    logic            busy, done, cmd_err;
    logic [W-1:0]    act;

    logic [W-1:0]    exp_q[$];
    int              total = 0;
    int              bad = 0;

    motor_sequencer #(
        .N_MOTORS(N), .SEL_W(SW), .RUN_CYCLES(RC), .PAUSE_CYCLES(PC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .stop(stop), .cmd_valid(cmd_valid),
        .cmd_motor(cmd_motor), .cmd_dir(cmd_dir), .cmd_seq(cmd_seq),
        .cmd_ready(cmd_ready), .motor_dir(motor_dir), .motor_en(motor_en),
        .led_idle(led_idle), .led_run(led_run), .led_pause(led_pause),
        .led_stop(led_stop), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    assign act = {cmd_ready, done, cmd_err, busy, led_idle, led_run, led_pause, led_stop,
                  motor_en, motor_dir};

    always #5 clk = ~clk;

    // Expected observable outputs for a given phase; only one motor can be live.
    function automatic logic [W-1:0] snap(int st, int motor, bit d, bit dn, bit er, bit rdy);
        logic [N-1:0]   en;
        logic [2*N-1:0] dr;
        en = '0;
        dr = '0;
        if (st == ST_RUN) begin
            en[motor] = 1'b1;
            dr[2*motor + (d ? 1 : 0)] = 1'b1;
        end
        return {rdy, dn, er, (st == ST_RUN) || (st == ST_PAUSE), st == ST_IDLE,
                st == ST_RUN, st == ST_PAUSE, st == ST_STOP, en, dr};
    endfunction

    task automatic check(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", act, e);
            end
        end
    end

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            stop      = 1'b0;
            exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    // t>0: stop asserted on edge t for h edges. rst_at>=0: async reset after edge rst_at.
    task automatic run_cmd(input int m, input bit d, input bit s, input int t, input int h,
                           input int rst_at);
        int len;
        int last;
        len  = (s ? N : 1) * (RC + PC);
        last = (t > 0) ? t + h : len;
        if (rst_at >= 0) last = rst_at;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd_valid = 1'b1;
                cmd_motor = SW'(m);
                cmd_dir   = d;
                cmd_seq   = s;
                stop      = 1'b0;
            end else begin
                cmd_valid = 1'($urandom);
                cmd_motor = SW'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_seq   = 1'($urandom);
                stop      = (t > 0) && (k >= t) && (k < t + h);
            end
            if ((t > 0) && (k >= t)) begin
                if (k < t + h) exp_q.push_back(snap(ST_STOP, 0, 1'b0, 1'b0, 1'b0, 1'b0));
                else           exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1));
            end else if (k == len) begin
                exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b1, 1'b0, 1'b1));
            end else begin
                int step;
                int ph;
                step = k / (RC + PC);
                ph   = k % (RC + PC);
                if (ph < RC) exp_q.push_back(snap(ST_RUN, (m + step) % N, d, 1'b0, 1'b0, 1'b0));
                else         exp_q.push_back(snap(ST_PAUSE, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        if (rst_at >= 0) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            stop      = 1'b0;
            #1 reset = 1'b0;
            #1 check("async_reset", act, snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #2 check("reset_held", act, snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(negedge clk);
            reset = 1'b1;
            exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        push_idle(1);
    endtask

    task automatic bad_cmd();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_motor = SW'(N + int'($urandom % ((1 << SW) - N)));
        cmd_dir   = 1'($urandom);
        cmd_seq   = 1'($urandom);
        stop      = 1'b0;
        exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b1, 1'b1));
        push_idle(1);
    endtask

    task automatic stop_in_idle(input int h);
        for (int k = 0; k <= h; k++) begin
            @(negedge clk);
            stop      = (k < h);
            cmd_valid = (k == 0) ? 1'b1 : 1'($urandom);
            cmd_motor = SW'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_seq   = 1'($urandom);
            if (k < h) exp_q.push_back(snap(ST_STOP, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            else       exp_q.push_back(snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        push_idle(1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        int sel;
        int m;
        bit s;
        int len;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("reset_state", act, snap(ST_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        reset = 1'b1;
        push_idle(2);

        run_cmd(1, 1'b0, 1'b0, 0, 0, -1);
        run_cmd(N - 1, 1'b1, 1'b1, 0, 0, -1);
        run_cmd(0, 1'b0, 1'b1, 4, 3, -1);
        bad_cmd();
        stop_in_idle(2);
        run_cmd(1, 1'b1, 1'b0, RC + PC, 1, -1);
        run_cmd(2, 1'b0, 1'b0, 0, 0, 3);
        run_cmd(0, 1'b1, 1'b0, 0, 0, RC + 1);

        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom % 5);
            m   = int'($urandom % N);
            s   = 1'($urandom);
            len = (s ? N : 1) * (RC + PC);
            case (sel)
                0, 1: begin
                    if ($urandom % 2 == 0) run_cmd(m, 1'($urandom), s, 0, 0, -1);
                    else run_cmd(m, 1'($urandom), s, 1 + int'($urandom % len),
                                 1 + int'($urandom % 4), -1);
                end
                2: bad_cmd();
                3: stop_in_idle(1 + int'($urandom % 3));
                default: begin
                    if ($urandom % 2 == 0) push_idle(1 + int'($urandom % 3));
                    else run_cmd(m, 1'($urandom), 1'b0, 0, 0, int'($urandom % (RC + PC)));
                end
            endcase
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
